// File: rtl/run_det_ctrl.sv
// Run-length detector session controller: counts runs of N equal serial bits
// (selected polarity) until a target number of matches, then pulses done.
module run_det_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [2:0]       run_len,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] target,
   input  logic             x_valid,
   input  logic             x,
   output logic             y,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] match_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;

   logic [2:0]       n_q;
   logic [1:0]       mode_q;
   logic [CNT_W-1:0] target_q;

   logic             last_bit_q;
   logic             have_last_q;
   logic [2:0]       run_cnt_q;

   logic [CNT_W-1:0] match_cnt_q;
   logic             busy_q, done_q, err_q;

   logic             cfg_legal, start_ok, start_bad;
   logic [2:0]       new_run;
   logic             pol_en;
   logic [CNT_W-1:0] cnt_inc;

   assign cfg_legal = (run_len >= 3'd2) && (mode != 2'b00) && (target != '0);
   assign start_ok  = (state_q == S_IDLE) && start && cfg_legal;
   assign start_bad = (state_q == S_IDLE) && start && !cfg_legal;
   assign cnt_inc   = match_cnt_q + CNT_W'(1);

   // Run length the current bit would produce, saturated at the latched N.
   always_comb begin
      new_run = 3'd1;
      if (have_last_q && (x == last_bit_q)) begin
         new_run = (run_cnt_q >= n_q) ? n_q : run_cnt_q + 3'd1;
      end
   end

   // mode[0] enables runs of ones, mode[1] runs of zeros.
   assign pol_en = x ? mode_q[0] : mode_q[1];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort wins over reaching the target.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_ok) state_d = S_RUN;
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (y && (cnt_inc == target_q)) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: Mealy match pulse.
   always_comb begin
      y = 1'b0;
      if ((state_q == S_RUN) && x_valid && (new_run == n_q) && pol_en) begin
         y = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_q         <= 3'd0;
         mode_q      <= 2'b00;
         target_q    <= '0;
         last_bit_q  <= 1'b0;
         have_last_q <= 1'b0;
         run_cnt_q   <= 3'd0;
         match_cnt_q <= '0;
      end else if (start_ok) begin
         n_q         <= run_len;
         mode_q      <= mode;
         target_q    <= target;
         last_bit_q  <= 1'b0;
         have_last_q <= 1'b0;
         run_cnt_q   <= 3'd0;
         match_cnt_q <= '0;
      end else if ((state_q == S_RUN) && x_valid) begin
         last_bit_q  <= x;
         have_last_q <= 1'b1;
         run_cnt_q   <= new_run;
         if (y) match_cnt_q <= cnt_inc;
      end
   end

   // Status flags registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= (state_d == S_RUN);
         done_q <= (state_d == S_DONE);
         err_q  <= start_bad;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_run_det_ctrl.sv
// Self-checking bench for run_det_ctrl: a behavioural model pushes expected
// outputs to a scoreboard queue that is popped as the DUT responds.
module tb_run_det_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, abort, x_valid, x;
   logic [2:0] run_len;
   logic [1:0] mode;
   logic [7:0] target;
   logic       y, busy, done, err;
   logic [7:0] match_cnt;

   run_det_ctrl #(.CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .run_len   (run_len),
      .mode      (mode),
      .target    (target),
      .x_valid   (x_valid),
      .x         (x),
      .y         (y),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .match_cnt (match_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       y;
      logic       busy;
      logic       done;
      logic       err;
      logic [7:0] cnt;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int trans  = 0;
   logic last_y;

   // Behavioural model: unsaturated run length compared against N.
   int         m_state = 0;
   int         m_run   = 0;
   logic       m_have  = 1'b0;
   logic       m_last  = 1'b0;
   logic [2:0] m_n     = 3'd0;
   logic [1:0] m_mode  = 2'b00;
   logic [7:0] m_tgt   = 8'd0;
   logic [7:0] m_cnt   = 8'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic s, input logic a, input logic [2:0] rl,
                       input logic [1:0] md, input logic [7:0] tg, input logic xv, input logic xb);
      int   run_after;
      logic pol, ey, ee;
      exp_t e;
      rst = r; start = s; abort = a; run_len = rl; mode = md; target = tg;
      x_valid = xv; x = xb;

      run_after = (m_have && (xb == m_last)) ? m_run + 1 : 1;
      pol = xb ? m_mode[0] : m_mode[1];
      ey  = (m_state == 1) && xv && pol && (run_after >= int'(m_n));
      ee  = 1'b0;
      if (r) begin
         m_state = 0; m_cnt = 8'd0; m_have = 1'b0; m_last = 1'b0; m_run = 0;
      end else begin
         case (m_state)
            0: if (s) begin
                  if (rl >= 3'd2 && md != 2'b00 && tg != 8'd0) begin
                     m_state = 1; m_n = rl; m_mode = md; m_tgt = tg;
                     m_cnt = 8'd0; m_have = 1'b0; m_run = 0;
                  end else begin
                     ee = 1'b1;
                  end
               end
            1: begin
                  if (ey) m_cnt = m_cnt + 8'd1;
                  if (xv) begin
                     m_last = xb; m_have = 1'b1;
                     m_run = (run_after > 16) ? 16 : run_after;
                  end
                  if (a) m_state = 0;
                  else if (ey && m_cnt == m_tgt) m_state = 2;
               end
            default: m_state = 0;
         endcase
      end
      exp_q.push_back('{y: ey, busy: (m_state == 1), done: (m_state == 2), err: ee, cnt: m_cnt});

      @(negedge clk);
      if (exp_q.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
      last_y = y;
      chk("y", {31'd0, y}, {31'd0, e.y});
      @(posedge clk);
      #1;
      chk("busy", {31'd0, busy}, {31'd0, e.busy});
      chk("done", {31'd0, done}, {31'd0, e.done});
      chk("err",  {31'd0, err},  {31'd0, e.err});
      chk("match_cnt", {24'd0, match_cnt}, {24'd0, e.cnt});
      trans++;
      $display("T%0d rst=%b st=%b ab=%b xv=%b x=%b y=%b busy=%b done=%b err=%b cnt=%0d",
               trans, r, s, a, xv, xb, last_y, busy, done, err, match_cnt);
   endtask

   task automatic bit_in(input logic xb);
      step(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 8'd0, 1'b1, xb);
   endtask

   task automatic idle_cyc();
      step(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 8'd0, 1'b0, 1'b0);
   endtask

   int   bits1[8] = '{1, 1, 1, 1, 0, 1, 1, 1};
   int   ypat1[8] = '{0, 0, 1, 1, 0, 0, 0, 1};
   int   bits2[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
   int   ypat2[8] = '{0, 0, 1, 0, 0, 1, 0, 0};

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; run_len = 3'd0; mode = 2'b00;
      target = 8'd0; x_valid = 1'b0; x = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state held with start and data asserted.
      step(1'b1, 1'b1, 1'b0, 3'd3, 2'b01, 8'd3, 1'b1, 1'b1);
      idle_cyc();

      // Runs of ones with overlap, session completes with done.
      step(1'b0, 1'b1, 1'b0, 3'd3, 2'b01, 8'd3, 1'b0, 1'b0);
      chk("s1_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         bit_in(bits1[i][0]);
         chk($sformatf("s1_y_b%0d", i + 1), {31'd0, last_y}, ypat1[i]);
      end
      chk("s1_done", {31'd0, done}, 32'd1);
      chk("s1_cnt", {24'd0, match_cnt}, 32'd3);
      bit_in(1'b1);
      chk("s1_cnt_hold", {24'd0, match_cnt}, 32'd3);

      // Illegal configurations are rejected.
      step(1'b0, 1'b1, 1'b0, 3'd1, 2'b01, 8'd3, 1'b0, 1'b0);
      chk("e_runlen", {31'd0, err}, 32'd1);
      step(1'b0, 1'b1, 1'b0, 3'd3, 2'b00, 8'd3, 1'b0, 1'b0);
      chk("e_mode", {31'd0, err}, 32'd1);
      step(1'b0, 1'b1, 1'b0, 3'd3, 2'b01, 8'd0, 1'b0, 1'b0);
      chk("e_target", {31'd0, err}, 32'd1);
      chk("e_busy", {31'd0, busy}, 32'd0);
      chk("e_cnt", {24'd0, match_cnt}, 32'd3);

      // Both polarities, x_valid low on alternate cycles.
      step(1'b0, 1'b1, 1'b0, 3'd3, 2'b11, 8'd4, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         bit_in(bits2[i][0]);
         chk($sformatf("s2_y_b%0d", i + 1), {31'd0, last_y}, ypat2[i]);
         step(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 8'd0, 1'b0, ~bits2[i][0]);
      end
      chk("s2_cnt", {24'd0, match_cnt}, 32'd2);
      chk("s2_busy", {31'd0, busy}, 32'd1);
      step(1'b0, 1'b0, 1'b1, 3'd0, 2'b00, 8'd0, 1'b0, 1'b0);

      // Runs of zeros then abort; restart clears the count.
      step(1'b0, 1'b1, 1'b0, 3'd2, 2'b10, 8'd5, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) bit_in(1'b0);
      step(1'b0, 1'b0, 1'b1, 3'd0, 2'b00, 8'd0, 1'b0, 1'b0);
      chk("s3_cnt", {24'd0, match_cnt}, 32'd2);
      chk("s3_idle", {31'd0, busy}, 32'd0);
      chk("s3_nodone", {31'd0, done}, 32'd0);
      step(1'b0, 1'b1, 1'b0, 3'd2, 2'b10, 8'd5, 1'b0, 1'b0);
      chk("s3_clr", {24'd0, match_cnt}, 32'd0);

      // Start during busy ignored, then reset mid-session overrides everything.
      for (int i = 0; i < 3; i++) bit_in(1'b0);
      step(1'b0, 1'b1, 1'b0, 3'd2, 2'b01, 8'd5, 1'b0, 1'b0);
      bit_in(1'b1);
      bit_in(1'b1);
      chk("s4_ignored", {24'd0, match_cnt}, 32'd2);
      step(1'b1, 1'b1, 1'b1, 3'd2, 2'b01, 8'd5, 1'b1, 1'b1);
      chk("s4_rst_busy", {31'd0, busy}, 32'd0);
      chk("s4_rst_cnt", {24'd0, match_cnt}, 32'd0);

      // Abort coinciding with the target match: counted but no done.
      step(1'b0, 1'b1, 1'b0, 3'd2, 2'b01, 8'd1, 1'b0, 1'b0);
      bit_in(1'b1);
      step(1'b0, 1'b0, 1'b1, 3'd0, 2'b00, 8'd0, 1'b1, 1'b1);
      chk("s5_y", {31'd0, last_y}, 32'd1);
      chk("s5_nodone", {31'd0, done}, 32'd0);
      chk("s5_cnt", {24'd0, match_cnt}, 32'd1);
      idle_cyc();

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 149) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 29) == 0),
              3'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)),
              8'($urandom_range(0, 4)),
              ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/run_det_ctrl.md
RUN_DET_CTRL -- requirements
Module: run_det_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of match target/counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to arm a detection session (sampled in IDLE only).
REQ-005 SHALL have port abort  input  1  terminate active session without done.
REQ-006 SHALL have port run_len  input  3  required run length N, legal 2..7, latched on accepted start.
REQ-007 SHALL have port mode  input  2  polarity: 01 = runs of 1, 10 = runs of 0, 11 = both, 00 = illegal; latched on accepted start.
REQ-008 SHALL have port target  input  CNT_W  number of matches ending the session, 0 illegal; latched on accepted start.
REQ-009 SHALL have port x_valid  input  1  qualifies serial bit x.
REQ-010 SHALL have port x  input  1  serial data bit.
REQ-011 SHALL have port y  output  1  Mealy match pulse, combinational from state and current x/x_valid.
REQ-012 SHALL have port busy  output  1  registered, high while in RUN.
REQ-013 SHALL have port done  output  1  registered, one-cycle pulse at successful session end.
REQ-014 SHALL have port err  output  1  registered, one-cycle pulse on rejected start.
REQ-015 SHALL have port match_cnt  output  CNT_W  registered count of matches in current/last session.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE; DONE lasts exactly one cycle then returns to IDLE.
REQ-017 IDLE: start=1 with run_len in 2..7, mode!=00, target!=0 SHALL latch config, clear match_cnt, clear run history, enter RUN (busy=1 next cycle).
REQ-018 IDLE: start=1 with any illegal field SHALL pulse err for one cycle, stay IDLE, leave match_cnt unchanged.
REQ-019 RUN: run history SHALL be last_bit, have_last flag and run_cnt (3 bits, saturating at latched N).
REQ-020 RUN, x_valid=1: new_run SHALL be run_cnt+1 (saturated at N) if have_last and x==last_bit, else 1; registers updated to last_bit=x, have_last=1, run_cnt=new_run.
REQ-021 y SHALL be 1 iff state=RUN, x_valid=1, new_run==N, and mode enables polarity of x; overlapping: every further same bit after a run of N pulses y again.
REQ-022 x_valid=0 SHALL leave history, counter and state unchanged and force y=0.
REQ-023 Each y=1 cycle SHALL increment match_cnt by 1; when incremented value equals target, next state SHALL be DONE (done=1, busy=0 that cycle) and later bits are ignored.
REQ-024 match_cnt SHALL hold its final value through DONE and IDLE until the next accepted start.
REQ-025 y SHALL be 0 in IDLE and DONE regardless of x.
REQ-026 start while in RUN or DONE SHALL be ignored.
REQ-027 abort=1 in RUN SHALL enter IDLE next cycle, no done, match_cnt held; a y computed in the abort cycle still counts; abort takes priority over reaching target (no done).
REQ-028 abort in IDLE or DONE SHALL have no effect.
REQ-029 Polarity change between two valid bits SHALL restart run at 1; a non-enabled polarity still updates history.

Reset
REQ-030 rst=1 SHALL, at the next rising edge, force IDLE, busy=0, done=0, err=0, match_cnt=0, run_cnt=0, have_last=0, last_bit=0; y=0 while state is IDLE.
REQ-031 rst SHALL override start, abort and x_valid in the same cycle, including mid-session.

Verification
REQ-032 N=3, mode=01, target=3, bits 1,1,1,1,0,1,1,1 -> y at bits 3,4,8; match_cnt=3; done one cycle after bit 8.
REQ-033 N=3, mode=11, target=4, bits 0,0,0,1,1,1,0,0 with x_valid low on alternate cycles -> y at bits 3 and 6 only, match_cnt=2, busy stays 1.
REQ-034 start with run_len=1, then with mode=00, then with target=0 -> err pulse each, busy never asserts, match_cnt unchanged.
REQ-035 N=2, mode=10, target=5, stream 0,0,0 then abort -> match_cnt=2, IDLE, no done; next valid start clears match_cnt to 0.
REQ-036 rst asserted in RUN with match_cnt=2 -> next cycle IDLE, all outputs 0; start during busy ignored (config unchanged).
